// File: rtl/run_sequencer_pkg.sv
// Shared types and default constants for the run sequencer and its BCD comparator.
package run_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        CRASHED = 2'd2
    } run_state_e;

    localparam int unsigned DEF_INIT_SPEED     = 6;
    localparam int unsigned DEF_MAX_SPEED      = 13;
    localparam int unsigned DEF_ACCEL_FRAMES   = 60;
    localparam int unsigned DEF_RESTART_FRAMES = 30;
    localparam int unsigned DEF_UNITS          = 5;

    localparam int unsigned SPEED_W = 4;
    localparam int unsigned DIGIT_W = 4;

endpackage

// File: rtl/run_sequencer_bcd_greater.sv
// Combinational unsigned compare of two BCD numbers (index 0 = most significant digit).
module run_sequencer_bcd_greater
    import run_sequencer_pkg::*;
#(
    parameter int unsigned UNITS = DEF_UNITS
) (
    input  logic [UNITS-1:0][DIGIT_W-1:0] a_i,
    input  logic [UNITS-1:0][DIGIT_W-1:0] b_i,
    output logic                          gt_c_o
);

    logic gt_c;
    logic decided_c;

    // The first differing digit, scanning from the MSD, decides the result.
    always_comb begin
        gt_c      = 1'b0;
        decided_c = 1'b0;
        for (int i = 0; i < int'(UNITS); i++) begin
            if (!decided_c && (a_i[i] != b_i[i])) begin
                decided_c = 1'b1;
                gt_c      = (a_i[i] > b_i[i]);
            end
        end
    end

    assign gt_c_o = gt_c;

endmodule

// File: rtl/run_sequencer.sv
// Game-run controller: starts/stops the distance meter, ramps speed and keeps the session high score.
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int unsigned INIT_SPEED     = DEF_INIT_SPEED,
    parameter int unsigned MAX_SPEED      = DEF_MAX_SPEED,
    parameter int unsigned ACCEL_FRAMES   = DEF_ACCEL_FRAMES,
    parameter int unsigned RESTART_FRAMES = DEF_RESTART_FRAMES,
    parameter int unsigned UNITS          = DEF_UNITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          timer_pulse,
    input  logic                          start,
    input  logic                          crash,
    input  logic [UNITS-1:0][DIGIT_W-1:0] digits,
    output logic [SPEED_W-1:0]            speed,
    output logic                          meter_rst,
    output logic [UNITS-1:0][DIGIT_W-1:0] hi_digits,
    output logic                          hi_paint,
    output run_state_e                    state
);

    localparam int unsigned CNT_MAX = (ACCEL_FRAMES > RESTART_FRAMES) ? ACCEL_FRAMES : RESTART_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    run_state_e                    state_q, state_d;
    logic [SPEED_W-1:0]            speed_q, speed_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [UNITS-1:0][DIGIT_W-1:0] hi_q, hi_d;
    logic                          hi_paint_q, hi_paint_d;
    logic                          meter_rst_q, meter_rst_d;
    logic                          start_q;
    logic                          start_armed_q;
    logic                          start_edge_c;
    logic                          hi_gt_c;

    run_sequencer_bcd_greater #(
        .UNITS (UNITS)
    ) u_bcd_greater (
        .a_i    (digits),
        .b_i    (hi_q),
        .gt_c_o (hi_gt_c)
    );

    // start_armed_q masks the first cycle after reset so a key already held is not an edge.
    assign start_edge_c = start_armed_q & start & ~start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            speed_q       <= '0;
            cnt_q         <= '0;
            hi_q          <= '0;
            hi_paint_q    <= 1'b0;
            meter_rst_q   <= 1'b0;
            start_q       <= 1'b0;
            start_armed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            speed_q       <= speed_d;
            cnt_q         <= cnt_d;
            hi_q          <= hi_d;
            hi_paint_q    <= hi_paint_d;
            meter_rst_q   <= meter_rst_d;
            start_q       <= start;
            start_armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        speed_d     = speed_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        meter_rst_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_edge_c) begin
                    meter_rst_d = 1'b1;
                    speed_d     = SPEED_W'(INIT_SPEED);
                    cnt_d       = '0;
                    state_d     = RUNNING;
                end
            end
            RUNNING: begin
                // Crash wins over any accel step or start edge in the same cycle.
                if (crash) begin
                    speed_d = '0;
                    cnt_d   = '0;
                    state_d = CRASHED;
                    if (hi_gt_c) begin
                        hi_d = digits;
                    end
                end else if (timer_pulse) begin
                    if (cnt_q == CNT_W'(ACCEL_FRAMES - 1)) begin
                        cnt_d   = '0;
                        speed_d = (speed_q >= SPEED_W'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                                   : speed_q + SPEED_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CRASHED: begin
                if (start_edge_c && (cnt_q >= CNT_W'(RESTART_FRAMES))) begin
                    meter_rst_d = 1'b1;
                    speed_d     = SPEED_W'(INIT_SPEED);
                    cnt_d       = '0;
                    state_d     = RUNNING;
                end else if (timer_pulse && (cnt_q < CNT_W'(RESTART_FRAMES))) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                speed_d = '0;
                cnt_d   = '0;
            end
        endcase

        hi_paint_d = hi_paint_q | (hi_d != '0);
    end

    assign state     = state_q;
    assign speed     = speed_q;
    assign meter_rst = meter_rst_q;
    assign hi_digits = hi_q;
    assign hi_paint  = hi_paint_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer.
module tb_run_sequencer;
    import run_sequencer_pkg::*;

    logic             clk;
    logic             rst;
    logic             timer_pulse;
    logic             start;
    logic             crash;
    logic [4:0][3:0]  digits;
    logic [3:0]       speed;
    logic             meter_rst;
    logic [4:0][3:0]  hi_digits;
    logic             hi_paint;
    run_state_e       state;

    int checks = 0;
    int errors = 0;
    logic [4:0][3:0] hi_exp;

    run_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .timer_pulse (timer_pulse),
        .start       (start),
        .crash       (crash),
        .digits      (digits),
        .speed       (speed),
        .meter_rst   (meter_rst),
        .hi_digits   (hi_digits),
        .hi_paint    (hi_paint),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0][3:0] bcd5(input int value);
        logic [4:0][3:0] r;
        int v;
        v = value;
        for (int i = 4; i >= 0; i--) begin
            r[i] = 4'(v % 10);
            v    = v / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            timer_pulse = 1'b1;
            tick();
            timer_pulse = 1'b0;
        end
    endtask

    task automatic start_edge();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_crash(input logic [4:0][3:0] d, input logic tp);
        digits      = d;
        crash       = 1'b1;
        timer_pulse = tp;
        tick();
        crash       = 1'b0;
        timer_pulse = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (state !== IDLE)      begin errors++; $display("FAIL reset_state got %0d want %0d", state, IDLE); end
        checks++; if (speed !== 4'd0)      begin errors++; $display("FAIL reset_speed got %0d want 0", speed); end
        checks++; if (meter_rst !== 1'b0)  begin errors++; $display("FAIL reset_meter_rst got %b want 0", meter_rst); end
        checks++; if (hi_digits !== '0)    begin errors++; $display("FAIL reset_hi got %h want 0", hi_digits); end
        checks++; if (hi_paint !== 1'b0)   begin errors++; $display("FAIL reset_hi_paint got %b want 0", hi_paint); end
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_rst_mid_run();
        logic mr_seen;
        start_edge();
        checks++; if (state !== RUNNING) begin errors++; $display("FAIL pre_rst_run got %0d want %0d", state, RUNNING); end
        pulses(5);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (state !== IDLE)  begin errors++; $display("FAIL async_rst_state got %0d want %0d", state, IDLE); end
        checks++; if (speed !== 4'd0)  begin errors++; $display("FAIL async_rst_speed got %0d want 0", speed); end
        start = 1'b1;
        tick();
        rst = 1'b0;
        mr_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (meter_rst) mr_seen = 1'b1;
        end
        checks++; if (mr_seen !== 1'b0)  begin errors++; $display("FAIL held_start_no_pulse got %b want 0", mr_seen); end
        checks++; if (state !== IDLE)    begin errors++; $display("FAIL held_start_state got %0d want %0d", state, IDLE); end
        checks++; if (speed !== 4'd0)    begin errors++; $display("FAIL held_start_speed got %0d want 0", speed); end
        checks++; if (hi_digits !== '0)  begin errors++; $display("FAIL held_start_hi got %h want 0", hi_digits); end
        checks++; if (hi_paint !== 1'b0) begin errors++; $display("FAIL held_start_hi_paint got %b want 0", hi_paint); end
        start = 1'b0;
        tick();
    endtask

    task automatic test_start_accel();
        start_edge();
        checks++; if (meter_rst !== 1'b1) begin errors++; $display("FAIL start_meter_rst got %b want 1", meter_rst); end
        checks++; if (speed !== 4'd6)     begin errors++; $display("FAIL start_speed got %0d want 6", speed); end
        checks++; if (state !== RUNNING)  begin errors++; $display("FAIL start_state got %0d want %0d", state, RUNNING); end
        tick();
        checks++; if (meter_rst !== 1'b0) begin errors++; $display("FAIL meter_rst_width got %b want 0", meter_rst); end
        pulses(59);
        checks++; if (speed !== 4'd6)  begin errors++; $display("FAIL speed_59 got %0d want 6", speed); end
        pulses(1);
        checks++; if (speed !== 4'd7)  begin errors++; $display("FAIL speed_60 got %0d want 7", speed); end
        pulses(360);
        checks++; if (speed !== 4'd13) begin errors++; $display("FAIL speed_420 got %0d want 13", speed); end
        pulses(180);
        checks++; if (speed !== 4'd13) begin errors++; $display("FAIL speed_600 got %0d want 13", speed); end
    endtask

    task automatic test_crash_accel();
        pulses(59);
        do_crash(bcd5(123), 1'b1);
        hi_exp = bcd5(123);
        checks++; if (speed !== 4'd0)      begin errors++; $display("FAIL crash_speed got %0d want 0", speed); end
        checks++; if (state !== CRASHED)   begin errors++; $display("FAIL crash_state got %0d want %0d", state, CRASHED); end
        checks++; if (hi_digits !== hi_exp) begin errors++; $display("FAIL crash_hi got %h want %h", hi_digits, hi_exp); end
        tick();
        checks++; if (hi_paint !== 1'b1)   begin errors++; $display("FAIL crash_hi_paint got %b want 1", hi_paint); end
    endtask

    task automatic run_and_crash(input int score);
        pulses(30);
        start_edge();
        checks++; if (state !== RUNNING) begin errors++; $display("FAIL rerun_state got %0d want %0d", state, RUNNING); end
        pulses(3);
        do_crash(bcd5(score), 1'b0);
    endtask

    task automatic test_hi_score();
        run_and_crash(99);
        checks++; if (hi_digits !== hi_exp) begin errors++; $display("FAIL hi_lower got %h want %h", hi_digits, hi_exp); end
        run_and_crash(123);
        checks++; if (hi_digits !== hi_exp) begin errors++; $display("FAIL hi_equal got %h want %h", hi_digits, hi_exp); end
        run_and_crash(130);
        hi_exp = bcd5(130);
        checks++; if (hi_digits !== hi_exp) begin errors++; $display("FAIL hi_higher got %h want %h", hi_digits, hi_exp); end
        run_and_crash(1000);
        hi_exp = bcd5(1000);
        checks++; if (hi_digits !== hi_exp) begin errors++; $display("FAIL hi_msd got %h want %h", hi_digits, hi_exp); end
    endtask

    task automatic test_restart_lockout();
        pulses(10);
        start_edge();
        checks++; if (state !== CRASHED)  begin errors++; $display("FAIL lockout_10_state got %0d want %0d", state, CRASHED); end
        checks++; if (meter_rst !== 1'b0) begin errors++; $display("FAIL lockout_10_meter_rst got %b want 0", meter_rst); end
        pulses(19);
        start_edge();
        checks++; if (state !== CRASHED)  begin errors++; $display("FAIL lockout_29_state got %0d want %0d", state, CRASHED); end
        checks++; if (speed !== 4'd0)     begin errors++; $display("FAIL lockout_29_speed got %0d want 0", speed); end
        pulses(1);
        start_edge();
        checks++; if (meter_rst !== 1'b1) begin errors++; $display("FAIL restart_meter_rst got %b want 1", meter_rst); end
        checks++; if (speed !== 4'd6)     begin errors++; $display("FAIL restart_speed got %0d want 6", speed); end
        checks++; if (state !== RUNNING)  begin errors++; $display("FAIL restart_state got %0d want %0d", state, RUNNING); end
        checks++; if (hi_digits !== hi_exp) begin errors++; $display("FAIL restart_hi got %h want %h", hi_digits, hi_exp); end
        tick();
        checks++; if (meter_rst !== 1'b0) begin errors++; $display("FAIL restart_meter_rst_width got %b want 0", meter_rst); end
    endtask

    task automatic test_crash_ignored();
        do_crash(bcd5(7), 1'b0);
        checks++; if (state !== CRASHED)    begin errors++; $display("FAIL low_crash_state got %0d want %0d", state, CRASHED); end
        do_crash(bcd5(99999), 1'b0);
        checks++; if (state !== CRASHED)    begin errors++; $display("FAIL crashed_crash_state got %0d want %0d", state, CRASHED); end
        checks++; if (hi_digits !== hi_exp) begin errors++; $display("FAIL crashed_crash_hi got %h want %h", hi_digits, hi_exp); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        do_crash(bcd5(500), 1'b0);
        tick();
        checks++; if (state !== IDLE)     begin errors++; $display("FAIL idle_crash_state got %0d want %0d", state, IDLE); end
        checks++; if (hi_digits !== '0)   begin errors++; $display("FAIL idle_crash_hi got %h want 0", hi_digits); end
        checks++; if (hi_paint !== 1'b0)  begin errors++; $display("FAIL idle_crash_hi_paint got %b want 0", hi_paint); end
        checks++; if (speed !== 4'd0)     begin errors++; $display("FAIL idle_crash_speed got %0d want 0", speed); end
    endtask

    initial begin
        rst         = 1'b1;
        timer_pulse = 1'b0;
        start       = 1'b0;
        crash       = 1'b0;
        digits      = '0;
        hi_exp      = '0;
        test_reset();
        test_rst_mid_run();
        test_start_accel();
        test_crash_accel();
        test_hi_score();
        test_restart_lockout();
        test_crash_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
